// File: rtl/mem_bus_responder.sv
// Single-window memory responder: four-phase read/write handshake with fixed
// per-operation latency into a local word array.
module mem_bus_responder #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int MEM_LOG2  = 8,
    parameter int BASE      = 0,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE-1:0] addr_in,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 read_q,
    input  logic                 write_q,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 read_dn,
    output logic                 write_dn,
    output logic                 bus_busy
);

    localparam int WIN_W = ADDR_SIZE - MEM_LOG2;
    localparam logic [WIN_W-1:0] BASE_IDX   = WIN_W'(BASE);
    localparam logic [3:0]       READ_LOAD  = 4'(READ_LAT - 1);
    localparam logic [3:0]       WRITE_LOAD = 4'(WRITE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [3:0]            count_reg;
    logic                  op_write_reg;
    logic [MEM_LOG2-1:0]   index_reg;
    logic [DATA_SIZE-1:0]  rdata_reg;
    logic                  armed_reg;
    logic [DATA_SIZE-1:0]  mem [0:(2**MEM_LOG2)-1];

    logic in_window;
    logic accept;
    logic req_live;
    logic finish;

    assign in_window = (addr_in[ADDR_SIZE-1:MEM_LOG2] == BASE_IDX);
    // armed_reg blocks acceptance on the first edge after reset is released
    assign accept    = (state_reg == IDLE) && armed_reg && in_window && (read_q || write_q);
    assign req_live  = op_write_reg ? write_q : read_q;
    assign finish    = (state_reg == WAIT) && req_live && (count_reg == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            armed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            armed_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = WAIT;
            WAIT: begin
                if (!req_live)
                    state_next = IDLE;
                else if (count_reg == 4'd0)
                    state_next = DONE;
            end
            DONE: if (!req_live) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus_busy = (state_reg != IDLE);
        read_dn  = (state_reg == DONE) && !op_write_reg;
        write_dn = (state_reg == DONE) && op_write_reg;
        data_out = read_dn ? rdata_reg : '0;
    end

    // Transaction context: latched on accept, counter runs down through WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= 4'd0;
            op_write_reg <= 1'b0;
            index_reg    <= '0;
            rdata_reg    <= '0;
        end else begin
            if (accept) begin
                op_write_reg <= write_q;
                index_reg    <= addr_in[MEM_LOG2-1:0];
                count_reg    <= write_q ? WRITE_LOAD : READ_LOAD;
            end else if ((state_reg == WAIT) && (count_reg != 4'd0)) begin
                count_reg <= count_reg - 4'd1;
            end
            if (finish && !op_write_reg)
                rdata_reg <= mem[index_reg];
        end
    end

    // Contents survive reset; a write lands only on the WAIT->DONE edge
    always_ff @(posedge clk) begin
        if (finish && op_write_reg)
            mem[index_reg] <= data_in;
    end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 32, meaning bus address width.
REQ-002 SHALL have parameter DATA_SIZE, default 32, meaning bus data width.
REQ-003 SHALL have parameter MEM_LOG2, default 8, meaning log2 of local word count (256 words).
REQ-004 SHALL have parameter BASE, default 0, meaning window index compared against addr_in[ADDR_SIZE-1:MEM_LOG2].
REQ-005 SHALL have parameter READ_LAT, default 2, meaning read latency in cycles (legal 1..15).
REQ-006 SHALL have parameter WRITE_LAT, default 1, meaning write latency in cycles (legal 1..15).
REQ-007 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-008 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-009 SHALL have port addr_in, input, ADDR_SIZE, meaning requester address, held stable while request high.
REQ-010 SHALL have port data_in, input, DATA_SIZE, meaning write data, held stable while write_q high.
REQ-011 SHALL have port read_q, input, 1, meaning level read request.
REQ-012 SHALL have port write_q, input, 1, meaning level write request.
REQ-013 SHALL have port data_out, output, DATA_SIZE, meaning read data.
REQ-014 SHALL have port read_dn, output, 1, meaning read complete.
REQ-015 SHALL have port write_dn, output, 1, meaning write complete.
REQ-016 SHALL have port bus_busy, output, 1, meaning responder owns a transaction.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, DONE, plus a 4-bit latency counter and a latched op/index register.
REQ-018 SHALL accept a request in IDLE only when addr_in[ADDR_SIZE-1:MEM_LOG2]==BASE; out-of-window requests are ignored, all outputs stay 0.
REQ-019 SHALL, when read_q and write_q are both high in IDLE, service the write and ignore the read.
REQ-020 SHALL, on accept at edge N, latch op and addr_in[MEM_LOG2-1:0], load counter with LAT-1, enter WAIT, and assert bus_busy from edge N.
REQ-021 SHALL decrement the counter each WAIT cycle and enter DONE when it is 0 with the request still high, so read_dn/write_dn rise at edge N+LAT.
REQ-022 SHALL commit a write to memory on the WAIT->DONE edge only; a write is never committed otherwise.
REQ-023 SHALL, on a read, register mem[index] into data_out on the WAIT->DONE edge and hold it while read_dn is high.
REQ-024 SHALL hold data_out at 0 whenever read_dn is low.
REQ-025 SHALL hold read_dn or write_dn (matching latched op) and bus_busy high in DONE until the latched request input is sampled low, then return to IDLE with both cleared on that edge (four-phase handshake).
REQ-026 SHALL, if the latched request drops during WAIT, abort to IDLE on the next edge with no memory write and no done pulse.
REQ-027 SHALL ignore the non-latched request input and addr_in changes while in WAIT or DONE.
REQ-028 SHALL allow a new request to be accepted no earlier than the edge after returning to IDLE (one idle cycle minimum between transactions).
REQ-029 SHALL store memory as 2**MEM_LOG2 words of DATA_SIZE bits, with no reset of contents.

Reset
REQ-030 SHALL, while rst_n is low, force state IDLE, counter 0, data_out 0, read_dn 0, write_dn 0, bus_busy 0 asynchronously.
REQ-031 SHALL, on reset mid-transaction, discard the transaction; an uncommitted write is lost, and memory contents are preserved.
REQ-032 SHALL leave reset synchronously on the first rising clk edge with rst_n high; no request is accepted on that same edge.

Verification
REQ-033 SHALL verify: write_q=1, addr=0x05, data=0xDEADBEEF, WRITE_LAT=1 -> write_dn high one edge after accept, held until write_q=0; then read 0x05, READ_LAT=2 -> read_dn at accept+2, data_out=0xDEADBEEF, 0 after read_dn drops.
REQ-034 SHALL verify: BASE=1, MEM_LOG2=8, read addr 0x0000_0042 -> no bus_busy, no read_dn for 20 cycles.
REQ-035 SHALL verify: read_q and write_q both high at addr 0x10, data 0x1234 -> write_dn only; subsequent read returns 0x1234.
REQ-036 SHALL verify: write to 0x20 with WRITE_LAT=4, write_q dropped after 2 cycles -> return to IDLE, no write_dn, mem[0x20] unchanged.
REQ-037 SHALL verify: rst_n pulsed low during WAIT of a read -> all outputs 0 immediately, state IDLE, prior memory data still readable.
REQ-038 SHALL verify: back-to-back reads at 0x01 then 0x02 -> second accepted no earlier than one cycle after first read_dn falls, correct data each.
